// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: op-field layout, FSM states, IO window base.
package mem_arbiter_pkg;

    // lsb_op field layout
    localparam int unsigned OP_STORE_BIT    = 3;
    localparam int unsigned OP_UNSIGNED_BIT = 2;
    localparam logic [1:0]  SIZE_B          = 2'b00;
    localparam logic [1:0]  SIZE_H          = 2'b01;
    localparam logic [1:0]  SIZE_W          = 2'b10;

    // Fetch is handled internally as an unextended-looking word load
    localparam logic [3:0]  OP_FETCH        = {2'b00, SIZE_W};

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StDone
    } state_e;

    // Number of byte beats for an access size; the reserved size code is treated as a word
    function automatic logic [2:0] op_nbytes(input logic [1:0] size);
        case (size)
            SIZE_B:  op_nbytes = 3'd1;
            SIZE_H:  op_nbytes = 3'd2;
            default: op_nbytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load-value extension: sign- or zero-extends byte and halfword loads, passes words through.
module mem_load_ext
    import mem_arbiter_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] raw,
    output logic [31:0] extended
);

    logic fill_b;
    logic fill_h;

    assign fill_b = ~op[OP_UNSIGNED_BIT] & raw[7];
    assign fill_h = ~op[OP_UNSIGNED_BIT] & raw[15];

    // Select the extension rule from the access size
    always_comb begin
        extended = raw;
        case (op[1:0])
            SIZE_B:  extended = {{24{fill_b}}, raw[7:0]};
            SIZE_H:  extended = {{16{fill_h}}, raw[15:0]};
            default: extended = raw;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the byte-wide memory port between instruction fetch and the LSB, splitting
// accesses into byte beats and assembling/extending read data.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned       ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(IO_BASE_DEFAULT)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear_flag,
    input  logic              io_buffer_full,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [31:0]       if_data,
    input  logic              lsb_req,
    input  logic [ADDR_W-1:0] lsb_addr,
    input  logic [31:0]       lsb_data,
    input  logic [3:0]        lsb_op,
    output logic              mem_ready,
    output logic [31:0]       mem_val
);

    state_e            state_q;
    logic [2:0]        cnt_q;
    logic [2:0]        nbytes_q;
    logic [ADDR_W-1:0] base_q;
    logic [3:0]        op_q;
    logic              is_fetch_q;
    logic [31:0]       wdata_q;
    logic [31:0]       lanes_q;
    logic              if_ready_q;
    logic              mem_ready_q;

    logic [2:0]        cnt_back;
    logic [ADDR_W-1:0] beat_addr;
    logic [ADDR_W-1:0] prev_addr;
    logic              io_hit;
    logic              wr_hold;
    logic              read_abort;
    logic [7:0]        wr_byte;
    logic [31:0]       lanes_next;
    logic [31:0]       ext_val;

    // Byte k arrives one cycle after beat k, so the lane being captured is cnt-1
    assign cnt_back  = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
    assign beat_addr = base_q + ADDR_W'(cnt_q);
    assign prev_addr = base_q + ADDR_W'(cnt_back);

    // Unsigned difference keeps the window test correct even near address wrap
    assign io_hit  = (beat_addr - IO_BASE) < ADDR_W'(8);
    assign wr_hold = io_hit & io_buffer_full;

    // Flush cancels any read, including one sitting in DONE; stores always complete
    assign read_abort = rdy_in & clear_flag &
                        ((state_q == StRead) |
                         ((state_q == StDone) & ~op_q[OP_STORE_BIT]));

    assign if_ready  = if_ready_q & rdy_in & ~read_abort;
    assign mem_ready = mem_ready_q & rdy_in & ~read_abort;

    // Store byte for the current beat
    always_comb begin
        wr_byte = wdata_q[7:0];
        case (cnt_q[1:0])
            2'd0: wr_byte = wdata_q[7:0];
            2'd1: wr_byte = wdata_q[15:8];
            2'd2: wr_byte = wdata_q[23:16];
            2'd3: wr_byte = wdata_q[31:24];
            default: wr_byte = wdata_q[7:0];
        endcase
    end

    // Merge the byte arriving this cycle into its lane
    always_comb begin
        lanes_next = lanes_q;
        case (cnt_back[1:0])
            2'd0: lanes_next[7:0]   = mem_din;
            2'd1: lanes_next[15:8]  = mem_din;
            2'd2: lanes_next[23:16] = mem_din;
            2'd3: lanes_next[31:24] = mem_din;
            default: lanes_next = lanes_q;
        endcase
    end

    mem_load_ext u_load_ext (
        .op      (op_q[2:0]),
        .raw     (lanes_next),
        .extended(ext_val)
    );

    // Drive the memory pins from the current state and beat
    always_comb begin
        mem_a    = '0;
        mem_dout = '0;
        mem_wr   = 1'b0;
        case (state_q)
            StRead: begin
                // While paused, re-present the address whose byte is still owed so that
                // mem_din carries it when rdy_in returns
                if (!rdy_in) begin
                    mem_a = prev_addr;
                end else if (cnt_q < nbytes_q) begin
                    mem_a = beat_addr;
                end
            end
            StWrite: begin
                mem_a    = beat_addr;
                mem_dout = wr_byte;
                mem_wr   = rdy_in & ~wr_hold;
            end
            default: begin
                mem_a = '0;
            end
        endcase
    end

    // Arbitration FSM, beat counter, lane assembly and registered result outputs
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            nbytes_q    <= '0;
            base_q      <= '0;
            op_q        <= '0;
            is_fetch_q  <= 1'b0;
            wdata_q     <= '0;
            lanes_q     <= '0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            if_data     <= '0;
            mem_val     <= '0;
        end else if (rdy_in) begin
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (!clear_flag) begin
                        if (lsb_req) begin
                            base_q     <= lsb_addr;
                            op_q       <= lsb_op;
                            wdata_q    <= lsb_data;
                            nbytes_q   <= op_nbytes(lsb_op[1:0]);
                            is_fetch_q <= 1'b0;
                            cnt_q      <= '0;
                            lanes_q    <= '0;
                            state_q    <= lsb_op[OP_STORE_BIT] ? StWrite : StRead;
                        end else if (if_req) begin
                            base_q     <= if_addr;
                            op_q       <= OP_FETCH;
                            wdata_q    <= '0;
                            nbytes_q   <= 3'd4;
                            is_fetch_q <= 1'b1;
                            cnt_q      <= '0;
                            lanes_q    <= '0;
                            state_q    <= StRead;
                        end
                    end
                end
                StRead: begin
                    if (clear_flag) begin
                        state_q <= StIdle;
                    end else begin
                        if (cnt_q != 3'd0) begin
                            lanes_q <= lanes_next;
                        end
                        if (cnt_q == nbytes_q) begin
                            state_q <= StDone;
                            if (is_fetch_q) begin
                                if_ready_q <= 1'b1;
                                if_data    <= lanes_next;
                            end else begin
                                mem_ready_q <= 1'b1;
                                mem_val     <= ext_val;
                            end
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                end
                StWrite: begin
                    if (!wr_hold) begin
                        if (cnt_q == nbytes_q - 3'd1) begin
                            state_q     <= StDone;
                            mem_ready_q <= 1'b1;
                            mem_val     <= '0;
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter with a small byte RAM model.
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        clear_flag = 1'b0;
    logic        io_buffer_full = 1'b0;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        if_ready;
    logic [31:0] if_data;
    logic        lsb_req = 1'b0;
    logic [31:0] lsb_addr = 32'h0;
    logic [31:0] lsb_data = 32'h0;
    logic [3:0]  lsb_op = 4'h0;
    logic        mem_ready;
    logic [31:0] mem_val;

    mem_arbiter dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .clear_flag    (clear_flag),
        .io_buffer_full(io_buffer_full),
        .mem_din       (mem_din),
        .mem_dout      (mem_dout),
        .mem_a         (mem_a),
        .mem_wr        (mem_wr),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_ready      (if_ready),
        .if_data       (if_data),
        .lsb_req       (lsb_req),
        .lsb_addr      (lsb_addr),
        .lsb_data      (lsb_data),
        .lsb_op        (lsb_op),
        .mem_ready     (mem_ready),
        .mem_val       (mem_val)
    );

    always #5 clk_in = ~clk_in;

    // Byte RAM: read data one cycle after the address, preloaded while in reset
    logic [7:0] ram [0:1023];
    always @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
            ram[10'h100] <= 8'h13;
            ram[10'h101] <= 8'h05;
            ram[10'h102] <= 8'h00;
            ram[10'h103] <= 8'h00;
            ram[10'h020] <= 8'h80;
            ram[10'h021] <= 8'h81;
            ram[10'h022] <= 8'h7F;
            ram[10'h023] <= 8'h00;
        end else if (mem_wr) begin
            ram[mem_a[9:0]] <= mem_dout;
        end
        mem_din <= ram[mem_a[9:0]];
    end

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_if[$];
    logic [31:0] exp_mem[$];
    logic [39:0] exp_wr[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Scoreboard monitor: compares every ready pulse and write beat against the queues
    task automatic monitor();
        logic [39:0] w;
        forever begin
            @(negedge clk_in);
            if (!rst_in) begin
                if (!rdy_in) check("wr_while_paused", 64'(mem_wr), 64'd0);
                if (if_ready || mem_ready) check("both_ready", 64'(if_ready & mem_ready), 64'd0);
                if (if_ready) begin
                    if (exp_if.size() == 0) check("if_unexpected", 64'(if_data), 64'hDEAD);
                    else check("if_data", 64'(if_data), 64'(exp_if.pop_front()));
                end
                if (mem_ready) begin
                    if (exp_mem.size() == 0) check("mem_unexpected", 64'(mem_val), 64'hDEAD);
                    else check("mem_val", 64'(mem_val), 64'(exp_mem.pop_front()));
                end
                if (mem_wr) begin
                    if (exp_wr.size() == 0) begin
                        check("wr_unexpected", {24'h0, mem_a, mem_dout}, 64'hDEAD);
                    end else begin
                        w = exp_wr.pop_front();
                        check("wr_beat", {24'h0, mem_a, mem_dout}, {24'h0, w});
                    end
                end
            end
        end
    endtask

    task automatic wait_ready(input bit fetch, output int lat);
        lat = 0;
        while (!(fetch ? if_ready : mem_ready) && lat < 30) begin
            tick();
            lat++;
        end
        if (lat >= 30) check("ready_timeout", 64'(lat), 64'd0);
    endtask

    // One LSB access with its result pushed to the scoreboard and latency checked
    task automatic lsb_access(input string name, input logic [3:0] op, input logic [31:0] addr,
                              input logic [31:0] data, input logic [31:0] val, input int lat_exp);
        int lat;
        exp_mem.push_back(val);
        lsb_req = 1'b1; lsb_op = op; lsb_addr = addr; lsb_data = data;
        tick();
        wait_ready(1'b0, lat);
        check(name, 64'(lat), 64'(lat_exp));
        lsb_req = 1'b0;
        tick();
    endtask

    task automatic push_word_writes(input logic [31:0] addr, input logic [31:0] data);
        for (int k = 0; k < 4; k++) exp_wr.push_back({addr + 32'(k), data[8*k +: 8]});
    endtask

    initial begin
        int lat;
        bit seen;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge clk_in);
        #1;
        check("reset_outputs", {mem_a, mem_dout, 5'h0, mem_wr, if_ready, mem_ready},
              64'd0);
        check("reset_data", {if_data, mem_val}, 64'd0);
        rst_in = 1'b0;
        tick();

        // 1. Fetch: address sequence, latency and assembled word
        exp_if.push_back(32'h0000_0513);
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        lat = 0;
        while (!if_ready && lat < 30) begin
            if (lat < 4) check("fetch_mem_a", 64'(mem_a), 64'(32'h100 + 32'(lat)));
            tick();
            lat++;
        end
        check("fetch_latency", 64'(lat), 64'd5);
        if_req = 1'b0;
        tick();

        // 2. Loads with each extension rule, including an unaligned halfword
        lsb_access("lb_lat",  4'b0000, 32'h20, 32'h0, 32'hFFFF_FF80, 2);
        lsb_access("lbu_lat", 4'b0100, 32'h20, 32'h0, 32'h0000_0080, 2);
        lsb_access("lh_lat",  4'b0001, 32'h20, 32'h0, 32'hFFFF_8180, 3);
        lsb_access("lhu_lat", 4'b0101, 32'h20, 32'h0, 32'h0000_8180, 3);
        lsb_access("lh_unal", 4'b0001, 32'h21, 32'h0, 32'h0000_7F81, 3);
        lsb_access("lw_lat",  4'b0010, 32'h20, 32'h0, 32'h007F_8180, 5);

        // 3. Word store, then read it back
        push_word_writes(32'h40, 32'hDEAD_BEEF);
        lsb_access("sw_lat", 4'b1010, 32'h40, 32'hDEAD_BEEF, 32'h0, 4);
        lsb_access("sw_readback", 4'b0010, 32'h40, 32'h0, 32'hDEAD_BEEF, 5);

        // 4. Simultaneous requests: LSB first, held through DONE, served once
        exp_mem.push_back(32'hFFFF_FF80);
        exp_if.push_back(32'h0000_0513);
        lsb_req = 1'b1; lsb_op = 4'b0000; lsb_addr = 32'h20;
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        wait_ready(1'b0, lat);
        check("arb_lsb_lat", 64'(lat), 64'd2);
        check("arb_fetch_waits", 64'(if_ready), 64'd0);
        tick();
        lsb_req = 1'b0;
        tick();
        wait_ready(1'b1, lat);
        check("arb_fetch_lat", 64'(lat), 64'd5);
        if_req = 1'b0;
        tick();

        // 5a. IO store held by a full IO buffer for three cycles
        exp_wr.push_back({32'h0003_0000, 8'h5A});
        exp_mem.push_back(32'h0);
        lsb_req = 1'b1; lsb_op = 4'b1000; lsb_addr = 32'h0003_0000; lsb_data = 32'h5A;
        io_buffer_full = 1'b1;
        tick();
        for (int c = 0; c < 3; c++) begin
            check("io_hold", 64'(mem_wr), 64'd0);
            tick();
        end
        io_buffer_full = 1'b0;
        wait_ready(1'b0, lat);
        check("io_store_lat", 64'(lat), 64'd1);
        lsb_req = 1'b0;
        tick();

        // 5b. Pause for two cycles in the middle of a word store
        push_word_writes(32'h50, 32'h1122_3344);
        exp_mem.push_back(32'h0);
        lsb_req = 1'b1; lsb_op = 4'b1010; lsb_addr = 32'h50; lsb_data = 32'h1122_3344;
        tick();
        tick();
        rdy_in = 1'b0;
        tick();
        tick();
        rdy_in = 1'b1;
        wait_ready(1'b0, lat);
        check("pause_store_lat", 64'(lat), 64'd3);
        lsb_req = 1'b0;
        tick();

        // 6a. Flush during a fetch read: no if_ready
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        tick();
        clear_flag = 1'b1; if_req = 1'b0;
        tick();
        clear_flag = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            seen |= if_ready;
            tick();
        end
        check("flush_fetch_no_ready", 64'(seen), 64'd0);

        // 6b. Flush during a word store: store still completes
        push_word_writes(32'h60, 32'hCAFE_F00D);
        exp_mem.push_back(32'h0);
        lsb_req = 1'b1; lsb_op = 4'b1010; lsb_addr = 32'h60; lsb_data = 32'hCAFE_F00D;
        tick();
        tick();
        clear_flag = 1'b1;
        tick();
        clear_flag = 1'b0;
        wait_ready(1'b0, lat);
        check("flush_store_lat", 64'(lat), 64'd2);
        lsb_req = 1'b0;
        tick();

        // 6c. Flush arriving in DONE of a load suppresses the pulse
        lsb_req = 1'b1; lsb_op = 4'b0000; lsb_addr = 32'h20;
        tick();
        tick();
        tick();
        clear_flag = 1'b1; lsb_req = 1'b0;
        #1;
        check("flush_done_ready", 64'(mem_ready), 64'd0);
        tick();
        clear_flag = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            seen |= mem_ready;
            tick();
        end
        check("flush_done_no_ready", 64'(seen), 64'd0);

        // 7. Asynchronous reset mid-fetch drops the access immediately
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        tick();
        check("pre_reset_mem_a", 64'(mem_a), 64'h101);
        #2;
        rst_in = 1'b1; if_req = 1'b0;
        #1;
        check("async_reset_outputs", {mem_a, mem_dout, 5'h0, mem_wr, if_ready, mem_ready},
              64'd0);
        tick();
        rst_in = 1'b0;
        repeat (8) tick();

        check("if_queue_empty", 64'(exp_if.size()), 64'd0);
        check("mem_queue_empty", 64'(exp_mem.size()), 64'd0);
        check("wr_queue_empty", 64'(exp_wr.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
